// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the data-memory port controller: access size coding,
// controller states and port ownership.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_D = 2'b00,
        SZ_W = 2'b01,
        SZ_H = 2'b10,
        SZ_B = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Wide enough for the largest legal read latency (7)
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Requester and memory-side signals of mem_port_ctrl; slave is the controller,
// master is the requesters plus memory.
interface mem_port_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_ack;
    logic [63:0]       d_rdata;

    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [63:0]       mem_wdata;
    logic              mem_wr;
    logic [1:0]        mem_tam;
    logic [63:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_raddr, mem_waddr, mem_wdata, mem_wr, mem_tam, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_raddr, mem_waddr, mem_wdata, mem_wr, mem_tam, busy
    );

endinterface

// File: rtl/mem_port_ctrl_load_extend.sv
// Combinational load-data extension: selects the low 1/2/4/8 bytes and
// sign- or zero-extends them to 64 bits.
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [63:0] i_data,
    input  size_t       i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_data
);
    logic w_fill;

    always_comb begin
        o_data = i_data;
        w_fill = 1'b0;
        case (i_size)
            SZ_W: begin
                w_fill = ~i_unsigned & i_data[31];
                o_data = {{32{w_fill}}, i_data[31:0]};
            end
            SZ_H: begin
                w_fill = ~i_unsigned & i_data[15];
                o_data = {{48{w_fill}}, i_data[15:0]};
            end
            SZ_B: begin
                w_fill = ~i_unsigned & i_data[7];
                o_data = {{56{w_fill}}, i_data[7:0]};
            end
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Round-robin sequencer sharing one memory port between instruction fetch and
// data load/store; counts the fixed read latency and returns data on req/ack.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned ADDR_W   = 64
)
(
    input  logic            Clk,
    input  logic            Reset,
    mem_port_ctrl_if.slave  bus
);
    state_t           r_state;
    owner_t           r_ptr;
    owner_t           r_own;
    size_t            r_size;
    logic             r_uns;
    logic [CNT_W-1:0] r_cnt;

    logic              w_gnt_d;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [63:0]       w_ext;

    // Data wins when it is the only requester or when the pointer favours it
    assign w_gnt_d   = bus.d_req && (!bus.if_req || r_ptr == OWN_D);
    assign w_rd_addr = w_gnt_d ? bus.d_addr : bus.if_addr;

    load_extend u_ext (
        .i_data     (bus.mem_rdata),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_ptr         <= OWN_D;
            r_own         <= OWN_IF;
            r_size        <= SZ_D;
            r_uns         <= 1'b0;
            r_cnt         <= '0;
            bus.if_ack    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_ack     <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wr    <= 1'b0;
            bus.mem_tam   <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        r_own    <= w_gnt_d ? OWN_D : OWN_IF;
                        r_ptr    <= w_gnt_d ? OWN_IF : OWN_D;
                        bus.busy <= 1'b1;
                        if (w_gnt_d && bus.d_we) begin
                            // Store completes in the single WRITE cycle, so its ack is raised now
                            r_state       <= WRITE;
                            bus.mem_wr    <= 1'b1;
                            bus.mem_waddr <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_tam   <= bus.d_size;
                            bus.d_ack     <= 1'b1;
                        end else begin
                            r_state       <= READ;
                            r_cnt         <= CNT_W'(READ_LAT);
                            bus.mem_raddr <= w_rd_addr;
                            r_size        <= w_gnt_d ? size_t'(bus.d_size) : SZ_W;
                            r_uns         <= w_gnt_d ? bus.d_unsigned : 1'b0;
                        end
                    end
                end
                WRITE: begin
                    r_state    <= IDLE;
                    bus.mem_wr <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.busy   <= 1'b0;
                end
                READ: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        if (r_own == OWN_D) begin
                            bus.d_rdata <= w_ext;
                            bus.d_ack   <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata[31:0];
                            bus.if_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.busy   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Sequencing and arbitration controller in front of the 64-bit byte-banked data memory, the 8 x 8-bit bank array with a `tam` size field.
- Shares the memory's single read/write port between two requesters: instruction fetch (read-only, 32-bit) and data load/store (1/2/4/8 bytes).
- Applies round-robin arbitration and counts the memory's fixed read latency.
- Sign- or zero-extends load data and returns results through a req/ack handshake.

Parameters:
- READ_LAT, 1, cycles from mem_raddr valid to mem_rdata valid (legal range 1-7).
- ADDR_W, 64, address width passed to the memory.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched instruction, equal to mem_rdata[31:0].
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = dword, 01 = word, 10 = half, 11 = byte (same coding as memory tam).
- d_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  64  store data, right-aligned.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
- d_rdata  out  64  extended load result.
- mem_raddr  out  ADDR_W  memory read address, registered.
- mem_waddr  out  ADDR_W  memory write address, registered.
- mem_wdata  out  64  memory write data, registered.
- mem_wr  out  1  memory write strobe.
- mem_tam  out  2  memory size field.
- mem_rdata  in  64  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, high):
  - State goes to IDLE; latency counter is cleared.
  - Round-robin pointer is set to DATA.
  - All outputs are 0.
  - An in-flight read is aborted: no ack is issued and the captured data is discarded.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - One requester high: grant it.
    - Both high: grant the requester the pointer selects.
    - On every grant, latch addr/size/unsigned/wdata/we and move the pointer to the other requester.
    - Granted data store: go to WRITE.
    - Any granted load or fetch: go to READ, with counter loaded to READ_LAT.
  - WRITE (1 cycle):
    - mem_wr=1, mem_waddr=latched addr, mem_wdata=latched wdata, mem_tam=latched size.
    - d_ack=1 in this cycle; next state IDLE.
  - READ:
    - mem_raddr=latched addr; counter decrements each cycle.
    - When counter reaches 0, register mem_rdata (extended per latched size/unsigned) into the output register; next state DONE.
  - DONE (1 cycle):
    - Assert the granted ack with rdata; next state IDLE.
- Latency, with req sampled in IDLE at edge E0:
  - Store: ack during cycle E0+1.
  - Read: ack exactly READ_LAT+2 cycles after E0.
- Handshake:
  - Exactly one ack pulse per grant.
  - A req still high in IDLE after its ack is a new request; requesters must drop req the cycle after ack if done.
- Extension on loads:
  - dword: pass through.
  - word: bits [31:0], bit 31 extended.
  - half: bits [15:0], bit 15 extended.
  - byte: bits [7:0], bit 7 extended.
  - In each case the extension is sign unless d_unsigned=1, then zero.
  - Fetch ignores d_size/d_unsigned and always returns mem_rdata[31:0].
- Other output rules:
  - mem_wr is high only in WRITE.
  - mem_raddr, mem_waddr and mem_tam hold their last value when not in use.
  - if_rdata and d_rdata hold their value until the next respective ack.
  - Acks are never asserted simultaneously.
- Addresses:
  - Passed through unmodified. No alignment check; 16-bit bank wrap is handled by the memory.
- Read-after-write:
  - No bypass. The memory write edge always precedes any subsequent read address (WRITE→IDLE→READ ordering).
- Starvation:
  - With both requesters held high continuously, grants strictly alternate.

Decomposition:
- Package mem_ctrl_pkg:
  - size_t enum: SZ_D=2'b00, SZ_W=2'b01, SZ_H=2'b10, SZ_B=2'b11.
  - state_t enum: IDLE, WRITE, READ, DONE.
  - owner_t enum: OWN_IF, OWN_D.
- Sub-module load_extend: combinational, (data64, size_t, unsigned) -> data64. Reused by the future byte-load path.

Test Plan:
- Reset mid-read: issue d_req load, assert Reset on cycle 2 -> no d_ack ever, busy=0, all mem_* outputs 0 on the cycle after Reset.
- Store byte then load (READ_LAT=1), mem[0x10..0x17] preloaded 0:
  - store d_size=11, d_addr=0x10, d_wdata=0x1122334455667788 -> mem_wr high exactly 1 cycle with mem_tam=11, mem_waddr=0x10; d_ack at E0+1.
  - signed byte load at 0x10 -> d_rdata=0xFFFFFFFFFFFFFF88.
  - unsigned byte load at 0x10 -> d_rdata=0x0000000000000088.
- Extension from mem_rdata=0x00000000_7FFF8001:
  - half signed -> 0xFFFFFFFFFFFF8001.
  - half unsigned -> 0x0000000000008001.
  - word signed -> 0x000000007FFF8001.
- Fetch at if_addr=0x4 with mem_rdata=0xDEADBEEF00000013, READ_LAT=1 -> if_rdata=0x00000013, if_ack 3 cycles after E0, d_ack stays 0.
- Contention: if_req and d_req held high from reset for 4 transactions -> grant order D, I, D, I; no double ack; each ack spacing matches its latency.
- READ_LAT=3: data load -> d_ack exactly 5 cycles after E0; mem_raddr stable for all READ cycles.
